// File: rtl/mips_cpu_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_pkg
// Shared CPU types. Holds the word type and the mult/div operation selector
// decoded in ID, plus the hilo_mdu sequencer states and iteration count.
// Also provides a small helper that turns a word into magnitude form.
// ---------------------------------------------------------------------------
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ALU_MULT = 1'b0,
    ALU_DIV  = 1'b1
  } mult_op_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_enum;

  localparam int MDU_ITER = 32;

  // Absolute value for signed operands, raw value for unsigned ones.
  // The magnitude of 0x8000_0000 is 0x8000_0000, which is still correct
  // when the word is read as unsigned.
  function automatic word_t mag(input word_t x, input logic sgn);
    return (sgn && x[31]) ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// ---------------------------------------------------------------------------
// hilo_mdu_if
// Bundle between the EX stage and hilo_mdu.
//   start/op/sign/src1/src2 : launch of a MULT/MULTU/DIV/DIVU
//   flush                   : abort the in-flight operation
//   hi_we/lo_we/hilo_wd     : MTHI/MTLO writes
//   stall                   : hold request to IF/ID/EX (combinational)
//   done                    : one-cycle completion pulse (registered)
//   hi/lo                   : architectural HI/LO (registered)
// master = EX side, slave = hilo_mdu.
// ---------------------------------------------------------------------------
interface hilo_mdu_if;
  import mips_cpu_pkg::*;

  logic        start;
  mult_op_enum op;
  logic        sign;
  word_t       src1;
  word_t       src2;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  word_t       hilo_wd;
  logic        stall;
  logic        done;
  word_t       hi;
  word_t       lo;

  modport master (
    output start, op, sign, src1, src2, flush, hi_we, lo_we, hilo_wd,
    input  stall, done, hi, lo
  );

  modport slave (
    input  start, op, sign, src1, src2, flush, hi_we, lo_we, hilo_wd,
    output stall, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_step.sv
// ---------------------------------------------------------------------------
// mdu_iter_step
// One iteration of the shared multiply/divide datapath (combinational).
//   i_op      : ALU_MULT (shift-add) or ALU_DIV (restoring step)
//   i_acc_hi  : upper accumulator / 33-bit partial remainder
//   i_lo_lsb  : multiplier bit consumed this step (LO[0])
//   i_lo_msb  : dividend bit shifted into the remainder (LO[31])
//   i_opnd    : multiplicand or divisor magnitude
//   o_acc_hi  : next upper accumulator / partial remainder
//   o_q_bit   : bit entering the LO side: the product bit leaving the
//               upper half (multiply, enters at LO[31]) or the quotient
//               bit (divide, enters at LO[0])
// ---------------------------------------------------------------------------
module mdu_iter_step
  import mips_cpu_pkg::*;
(
  input  mult_op_enum i_op,
  input  logic [32:0] i_acc_hi,
  input  logic        i_lo_lsb,
  input  logic        i_lo_msb,
  input  word_t       i_opnd,
  output logic [32:0] o_acc_hi,
  output logic        o_q_bit
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [33:0] w_diff;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the if/else can leave it unassigned and infer a latch.
    o_acc_hi = i_acc_hi;
    o_q_bit  = 1'b0;

    w_sum   = i_acc_hi + (i_lo_lsb ? {1'b0, i_opnd} : 33'd0);
    w_shift = {i_acc_hi[31:0], i_lo_msb};
    // The shifted remainder can reach 2^33-1, so borrow needs a 34th bit.
    w_diff  = {1'b0, w_shift} - {2'b00, i_opnd};

    if (i_op == ALU_DIV) begin
      if (!w_diff[33]) begin
        o_acc_hi = w_diff[32:0];
        o_q_bit  = 1'b1;
      end else begin
        o_acc_hi = w_shift;
        o_q_bit  = 1'b0;
      end
    end else begin
      o_acc_hi = {1'b0, w_sum[32:1]};
      o_q_bit  = w_sum[0];
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// ---------------------------------------------------------------------------
// hilo_mdu
// Multi-cycle multiply/divide unit and owner of HI/LO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hilo_mdu_if.slave (launch, flush, MTHI/MTLO, stall, done,
//                hi, lo)
// Operands are latched as magnitudes, run through 32 iterations of
// mdu_iter_step, then sign-corrected in FIX and written to HI/LO.
// Optional build macro MDU_SINGLE_CYCLE_MULT_EN: multiplies use a registered
// '*' and complete without stalling; divides still iterate.
// ---------------------------------------------------------------------------
module hilo_mdu
  import mips_cpu_pkg::*;
#(
  parameter int ITER = MDU_ITER
)(
  input  logic       clk,
  input  logic       rst_n,
  hilo_mdu_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER);

  mdu_state_enum    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mult_op_enum      r_op;
  logic             r_neg_q;     // product / quotient negative
  logic             r_neg_r;     // remainder negative (dividend sign)
  logic             r_div_zero;
  logic [32:0]      r_acc_hi;
  word_t            r_acc_lo;
  word_t            r_opnd;
  word_t            r_hi;
  word_t            r_lo;
  logic             r_done;

  logic             w_fast_mult;
  logic             w_launch;
  logic [32:0]      w_acc_hi_nxt;
  logic             w_q_bit;
  logic [63:0]      w_prod_mag;
  logic [63:0]      w_prod;
  word_t            w_quot;
  word_t            w_rem;

`ifdef MDU_SINGLE_CYCLE_MULT_EN
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_fast_prod;

  // Low 64 bits of the product of the sign/zero-extended operands are the
  // exact signed/unsigned 64-bit product.
  assign w_a64       = {{32{bus.sign & bus.src1[31]}}, bus.src1};
  assign w_b64       = {{32{bus.sign & bus.src2[31]}}, bus.src2};
  assign w_fast_prod = w_a64 * w_b64;
  assign w_fast_mult = bus.start & ~bus.flush & (r_state == IDLE) &
                       (bus.op == ALU_MULT);
`else
  assign w_fast_mult = 1'b0;
`endif

  assign w_launch  = bus.start & ~bus.flush & (r_state == IDLE) & ~w_fast_mult;
  assign bus.stall = rst_n & (w_launch | (r_state == RUN) | (r_state == FIX));
  assign bus.done  = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

  mdu_iter_step u_step (
    .i_op     (r_op),
    .i_acc_hi (r_acc_hi),
    .i_lo_lsb (r_acc_lo[0]),
    .i_lo_msb (r_acc_lo[31]),
    .i_opnd   (r_opnd),
    .o_acc_hi (w_acc_hi_nxt),
    .o_q_bit  (w_q_bit)
  );

  // Sign fixup. Divide by zero leaves the remainder equal to the dividend
  // magnitude, so re-applying the dividend sign gives back src1 exactly.
  assign w_prod_mag = {r_acc_hi[31:0], r_acc_lo};
  assign w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
  assign w_quot     = r_div_zero ? '1 : (r_neg_q ? -r_acc_lo : r_acc_lo);
  assign w_rem      = r_neg_r ? -r_acc_hi[31:0] : r_acc_hi[31:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_state_nxt = RUN;
      RUN: begin
        if (bus.flush)                          w_state_nxt = IDLE;
        else if (r_cnt == CNT_W'(ITER - 1))     w_state_nxt = FIX;
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain flops, not a memory array, so all of them are
    // reset; a flushed/reset op leaves no stale sign or count behind.
    if (!rst_n) begin
      r_cnt      <= '0;
      r_op       <= ALU_MULT;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.hi_we) r_hi <= bus.hilo_wd;
          if (bus.lo_we) r_lo <= bus.hilo_wd;
          if (w_launch) begin
            r_op       <= bus.op;
            r_neg_q    <= bus.sign & (bus.src1[31] ^ bus.src2[31]);
            r_neg_r    <= bus.sign & bus.src1[31];
            r_div_zero <= (bus.src2 == '0);
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            if (bus.op == ALU_DIV) begin
              r_acc_lo <= mag(bus.src1, bus.sign);
              r_opnd   <= mag(bus.src2, bus.sign);
            end else begin
              r_acc_lo <= mag(bus.src2, bus.sign);
              r_opnd   <= mag(bus.src1, bus.sign);
            end
          end
`ifdef MDU_SINGLE_CYCLE_MULT_EN
          // Placed after the MT writes so the product wins on a collision.
          if (w_fast_mult) begin
            {r_hi, r_lo} <= w_fast_prod;
            r_done       <= 1'b1;
          end
`endif
        end
        RUN: begin
          r_cnt    <= r_cnt + 1'b1;
          r_acc_hi <= w_acc_hi_nxt;
          r_acc_lo <= (r_op == ALU_DIV) ? {r_acc_lo[30:0], w_q_bit}
                                        : {w_q_bit, r_acc_lo[31:1]};
        end
        FIX: begin
          if (!bus.flush) begin
            if (r_op == ALU_DIV) {r_hi, r_lo} <= {w_rem, w_quot};
            else                 {r_hi, r_lo} <= w_prod;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/hilo_mdu.md
# hilo_mdu

Multi-cycle multiply/divide unit and owner of the HI/LO architectural registers. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU operations decoded in ID (`mult_op`, `aluop.sign`). It sequences a shared 32-iteration shift/add-subtract datapath and requests a pipeline stall while busy. It also serves MTHI/MTLO writes and the MFHI/MFLO read values.

## Interface
Parameters:
- `ITER`, 32: iteration count of the shared datapath. Fixed to the word width and not overridable in practice.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: EX holds a valid mult/div op this cycle.
- `op`  in  mult_op_enum: ALU_MULT or ALU_DIV.
- `sign`  in  1: 1 selects signed (MULT/DIV), 0 selects unsigned (MULTU/DIVU).
- `src1`  in  word_t: multiplicand or dividend (R[rs]).
- `src2`  in  word_t: multiplier or divisor (R[rt]).
- `flush`  in  1: abort the in-flight op.
- `hi_we`  in  1: MTHI write enable.
- `lo_we`  in  1: MTLO write enable.
- `hilo_wd`  in  word_t: MTHI/MTLO data.
- `stall`  out  1: combinational hold request to the IF/ID/EX registers.
- `done`  out  1: registered one-cycle completion pulse.
- `hi`  out  word_t: registered HI.
- `lo`  out  word_t: registered LO.

## Operation
States: IDLE, RUN, FIX.
- **IDLE**
  - `start` latches operands into magnitude form: the absolute value when `sign=1`, raw otherwise.
  - It also latches `op`, `sign`, the result-sign flags, and clears `cnt` to 0.
  - Next state is RUN.
- **RUN**
  - Each cycle performs one iteration and increments `cnt`.
  - At `cnt==31` the next state is FIX.
  - Multiply: shift-add on a 64-bit accumulator (`{acc_hi, mplier}`).
  - Divide: restoring step on a 33-bit partial remainder; the quotient bit is shifted into the LO side.
- **FIX**
  - Apply sign correction and write HI/LO.
  - Raise `done` for the next cycle.
  - Next state is IDLE.

Result rules:
- Multiply: {HI,LO} = 64-bit product. It is negated when `sign` is set and the operand signs differ.
- Divide: LO = quotient, HI = remainder.
  - The quotient is negative iff the operand signs differ.
  - The remainder takes the dividend's sign.
- Divide by zero takes normal latency and gives HI = `src1`, LO = 32'hFFFF_FFFF, regardless of `sign`.
- Signed 0x8000_0000 / 0xFFFF_FFFF gives LO = 0x8000_0000, HI = 0.

Stall and control rules:
- `stall = (start & IDLE) | RUN | FIX`.
- `start` outside IDLE is ignored. The held EX instruction is not re-launched.
- `flush` in RUN or FIX forces IDLE at the next edge. HI/LO stay unchanged and no `done` is produced.
- `flush` together with `start` in IDLE means no launch and `stall` is low.
- `hi_we`/`lo_we` take effect only in IDLE. They are ignored in RUN and FIX.
- If a FIX write and an MT write fall on the same edge, the FIX result wins.

## Timing
- Reset values: state IDLE, `cnt` 0, `hi` 0, `lo` 0, `done` 0. `stall` is 0 while reset is asserted.
- Reset asserted mid-op returns to IDLE immediately and the result is discarded.
- Iterative op with `start` in cycle n:
  - `stall` high in cycles n through n+33.
  - HI/LO updated at the edge ending cycle n+33.
  - `done` high in cycle n+34.
  - Total 34 stall cycles.
- MTHI/MTLO: the value is visible on `hi`/`lo` in the cycle after `*_we`.
- MFHI/MFLO read `hi`/`lo` directly. EX forwarding of a same-cycle MT write is handled outside this block.

## Configuration
- `MDU_SINGLE_CYCLE_MULT_EN` defined:
  - Multiply uses a registered `*` operator.
  - HI/LO are written at the edge ending the `start` cycle and `done` is high in the next cycle.
  - `stall` is never asserted for multiply; the state stays IDLE.
  - Divide is unchanged.
- `MDU_SINGLE_CYCLE_MULT_EN` undefined: multiply uses the 34-cycle iterative path defined above.

## Structure
- `mips_cpu_pkg` gets `mdu_state_enum` (IDLE/RUN/FIX) and the constant `MDU_ITER = 32`.
- `mult_op_enum` and `word_t` are already in the package and are reused.
- One sub-module, `mdu_iter_step`: a combinational single-iteration kernel taking the accumulator, operand and op, and returning the next accumulator and quotient bit. It is instantiated once; the FSM, counter, sign fixup and HI/LO registers live in `hilo_mdu`.

## Test plan
- Unsigned MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001; `stall` is high for exactly 34 cycles and `done` pulses once.
- Signed DIV −7 / 2 → LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
- DIVU 100 / 0 → HI = 100, LO = 0xFFFF_FFFF; latency is 34 cycles.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- Flush at RUN cycle 10 after HI/LO were preset via MTHI 0x1234 / MTLO 0x5678 → HI/LO keep 0x1234/0x5678; no `done`; `stall` drops next cycle.
- `rst_n` low mid-RUN → state IDLE and HI = LO = 0 immediately. With `MDU_SINGLE_CYCLE_MULT_EN`, MULT −3 × 5 → LO = 0xFFFF_FFF1, HI = 0xFFFF_FFFF after one edge, and `stall` stays 0.
